// File: rtl/inst_fetch_queue_pkg.sv
// Shared constants and payload type for the instruction-fetch front end.
package inst_fetch_queue_pkg;

    localparam int unsigned INST_W = 32;

    localparam logic [INST_W-1:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [INST_W-1:0] NOP          = 32'h0000_0000;
    localparam logic [INST_W-1:0] PC_STEP      = 32'd4;

    // One queued fetch: the word and the address it came from.
    typedef struct packed {
        logic [INST_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_queue_fetch_fifo.sv
// Synchronous FIFO of {pc, inst} entries with flush; head is read straight from storage.
module fetch_fifo
    import inst_fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  fetch_entry_t             i_wdata,
    output fetch_entry_t             o_rdata,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    fetch_entry_t       r_mem [DEPTH];
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               w_push;
    logic               w_pop;

    // Flush wins over both push and pop; pop of an empty queue is ignored.
    always_comb begin
        w_push = i_push & ~i_flush;
        w_pop  = i_pop & ~i_flush & ~o_empty;
    end

    // Pointer, occupancy and storage update.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '{pc: NOP, inst: NOP};
            end
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_empty = (r_count == CNT_W'(0));
    assign o_count = r_count;

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction-fetch front end: PC register, InstMem request, decode-side queue, redirect.
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        ce,
    output logic [31:0] addr,
    input  logic [31:0] data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [31:0]        r_pc;
    logic               w_pop;
    logic               w_empty;
    logic [CNT_W-1:0]   w_count;
    fetch_entry_t       w_head;
    fetch_entry_t       w_wdata;

    // Fetch whenever a slot is free now or freed by this cycle's pop; redirect suppresses it.
    always_comb begin
        w_pop   = inst_valid & inst_ready;
        ce      = ~rst & ~redirect_valid & ((w_count < CNT_W'(DEPTH)) | w_pop);
        w_wdata = '{pc: r_pc, inst: data};
    end

    // Program counter: reset, redirect target (word aligned), or sequential step after a fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_pc <= {redirect_pc[31:2], 2'b00};
        end else if (ce) begin
            r_pc <= r_pc + PC_STEP;
        end
    end

    fetch_fifo #(
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (ce),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .i_wdata (w_wdata),
        .o_rdata (w_head),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign addr       = r_pc;
    assign inst_valid = ~w_empty;
    assign inst       = w_head.inst;
    assign inst_pc    = w_head.pc;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: directed scenarios plus random traffic against a queue model.
module tb_inst_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic [31:0] addr;
    logic [31:0] data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;

    always #5 clk = ~clk;

    // InstMem contents: two fixed words at the bottom, a scrambled address pattern elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: mem_word = 32'h0000_f025;
            32'h0000_0004: mem_word = 32'h241d_1000;
            default:       mem_word = {a[15:0] ^ 16'h5a5a, a[31:16]} ^ 32'h1357_9bdf;
        endcase
    endfunction

    assign data = mem_word(addr);

    inst_fetch_queue dut (
        .clk            (clk),
        .rst            (rst),
        .ce             (ce),
        .addr           (addr),
        .data           (data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready)
    );

    // Reference model: a plain PC and a bounded queue of (pc, word) pairs.
    localparam int MDEPTH = 4;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] m_pc  = 32'h0;
    logic [31:0] q_pc[$];
    logic [31:0] q_inst[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, check outputs mid-cycle against the model, then advance the model.
    task automatic step(input logic r, input logic rv, input logic [31:0] rp, input logic rd);
        logic e_valid, e_pop, e_ce;
        rst            = r;
        redirect_valid = rv;
        redirect_pc    = rp;
        inst_ready     = rd;
        @(negedge clk);
        e_valid = (q_pc.size() != 0);
        e_pop   = e_valid && rd;
        e_ce    = !r && !rv && ((q_pc.size() < MDEPTH) || e_pop);
        chk("ce", {31'b0, ce}, {31'b0, e_ce});
        chk("addr", addr, m_pc);
        chk("inst_valid", {31'b0, inst_valid}, {31'b0, e_valid});
        if (e_valid && inst_valid) begin
            chk("inst", inst, q_inst[0]);
            chk("inst_pc", inst_pc, q_pc[0]);
        end
        @(posedge clk);
        if (r) begin
            m_pc = 32'h0;
            q_pc.delete();
            q_inst.delete();
        end else if (rv) begin
            q_pc.delete();
            q_inst.delete();
            m_pc = rp & 32'hFFFF_FFFC;
        end else begin
            if (e_pop) begin
                void'(q_pc.pop_front());
                void'(q_inst.pop_front());
            end
            if (e_ce) begin
                q_pc.push_back(m_pc);
                q_inst.push_back(mem_word(m_pc));
                m_pc = m_pc + 32'd4;
            end
        end
        #1;
    endtask

    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        inst_ready     = 1'b0;
        @(posedge clk);
        #1;

        // T1: reset then streaming at one word per cycle
        step(1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        chk("t1_rst_inst", inst, 32'h0);
        chk("t1_rst_inst_pc", inst_pc, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("t1_first_inst", inst, 32'h0000_f025);
        chk("t1_first_pc", inst_pc, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("t1_second_inst", inst, 32'h241d_1000);
        chk("t1_second_pc", inst_pc, 32'h4);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

        // T2: backpressure from reset release, then drain
        step(1'b1, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
        chk("t2_addr_stall", addr, 32'h10);
        chk("t2_head_pc", inst_pc, 32'h0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

        // T3: redirect while the head is being accepted
        step(1'b0, 1'b1, 32'h20, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 32'h1BB, 1'b1);
        chk("t3_flushed_valid", {31'b0, inst_valid}, 32'h0);
        chk("t3_target_addr", addr, 32'h1B8);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("t3_target_pc", inst_pc, 32'h1B8);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

        // T4: full queue with a single-cycle pop
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

        // T5: PC wraps past the top of the address space
        step(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("t5_wrap_first", inst_pc, 32'hFFFF_FFF8);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("t5_wrap_second", inst_pc, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("t5_wrap_third", inst_pc, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("t5_wrap_fourth", inst_pc, 32'h4);

        // T6: reset overrides a redirect with entries queued
        step(1'b0, 1'b1, 32'h40, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b1, 32'h80, 1'b1);
        chk("t6_valid", {31'b0, inst_valid}, 32'h0);
        chk("t6_addr", addr, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b1);

        // Random traffic: mostly-ready decode, occasional redirects and resets
        for (int i = 0; i < 400; i++) begin
            logic        r_r, r_v, r_rd;
            logic [31:0] r_pc;
            r_r  = ($urandom_range(0, 99) < 2);
            r_v  = ($urandom_range(0, 99) < 10);
            r_rd = ($urandom_range(0, 99) < 65);
            r_pc = $urandom;
            step(r_r, r_v, r_pc, r_rd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
